// File: rtl/writeback_arbiter_if.sv
// Writeback arbiter bus: pipeline writeback inputs, long-latency result handshake and
// register-file write port. The arbiter uses the slave modport.
interface writeback_arbiter_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned RADDR_W = 5,
  parameter int unsigned Q_DEPTH = 4
);
  logic [XLEN-1:0]            dmem_readdata_w_in;
  logic [XLEN-1:0]            execute_out_w_in;
  logic [XLEN-1:0]            pc_plus4_w_in;
  logic [1:0]                 reg_writedata_sel_w;
  logic [2:0]                 load_funct3_w;
  logic [1:0]                 load_byte_off_w;
  logic [RADDR_W-1:0]         reg_write_addr_w_in;
  logic                       reg_write_en_w_in;
  logic                       lu_valid;
  logic                       lu_ready;
  logic [XLEN-1:0]            lu_data;
  logic [RADDR_W-1:0]         lu_addr;
  logic [XLEN-1:0]            reg_writedata_w;
  logic [RADDR_W-1:0]         reg_write_addr_w_out;
  logic                       reg_write_en_w_out;
  logic [$clog2(Q_DEPTH):0]   q_count;

  modport master (
    output dmem_readdata_w_in, execute_out_w_in, pc_plus4_w_in, reg_writedata_sel_w,
    output load_funct3_w, load_byte_off_w, reg_write_addr_w_in, reg_write_en_w_in,
    output lu_valid, lu_data, lu_addr,
    input  lu_ready, reg_writedata_w, reg_write_addr_w_out, reg_write_en_w_out, q_count
  );

  modport slave (
    input  dmem_readdata_w_in, execute_out_w_in, pc_plus4_w_in, reg_writedata_sel_w,
    input  load_funct3_w, load_byte_off_w, reg_write_addr_w_in, reg_write_en_w_in,
    input  lu_valid, lu_data, lu_addr,
    output lu_ready, reg_writedata_w, reg_write_addr_w_out, reg_write_en_w_out, q_count
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Merges pipeline writeback with queued long-latency results onto one register-file port.
// Define WB_LOAD_EXT_EN to align and sign/zero-extend load data here.
module writeback_arbiter #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned RADDR_W = 5,
  parameter int unsigned Q_DEPTH = 4
) (
  input logic                clk,
  input logic                rst,
  writeback_arbiter_if.slave wb
);
  localparam int unsigned PtrW = $clog2(Q_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0]    head_q, tail_q;
  logic [CntW-1:0]    count_q, count_d;
  logic [Q_DEPTH-1:0] valid_q, valid_d;
  logic [RADDR_W-1:0] addr_q [Q_DEPTH];
  logic [XLEN-1:0]    data_q [Q_DEPTH];

  logic            slot_busy, q_empty, q_full, head_valid;
  logic            push, push_valid, pop, drain;
  logic [XLEN-1:0] load_data, sel_data;

  assign slot_busy  = wb.reg_write_en_w_in && (wb.reg_write_addr_w_in != '0);
  assign q_empty    = (count_q == '0);
  assign q_full     = (count_q == CntW'(Q_DEPTH));
  assign head_valid = valid_q[head_q];

  assign push       = wb.lu_valid && !q_full;
  // A push aimed at x0 or at the register the pipeline is writing right now is dead on arrival.
  assign push_valid = (wb.lu_addr != '0) &&
                      !(slot_busy && (wb.lu_addr == wb.reg_write_addr_w_in));
  assign drain      = !slot_busy && !q_empty && head_valid;
  assign pop        = !q_empty && (drain || !head_valid);

`ifdef WB_LOAD_EXT_EN
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte = '0;
    ld_half = '0;
    case (wb.load_byte_off_w)
      2'd0: begin
        ld_byte = wb.dmem_readdata_w_in[7:0];
        ld_half = wb.dmem_readdata_w_in[15:0];
      end
      2'd1: begin
        ld_byte = wb.dmem_readdata_w_in[15:8];
        ld_half = wb.dmem_readdata_w_in[23:8];
      end
      2'd2: begin
        ld_byte = wb.dmem_readdata_w_in[23:16];
        ld_half = wb.dmem_readdata_w_in[31:16];
      end
      default: begin
        ld_byte = wb.dmem_readdata_w_in[31:24];
        ld_half = {8'h00, wb.dmem_readdata_w_in[31:24]};
      end
    endcase
  end

  always_comb begin
    load_data = wb.dmem_readdata_w_in;
    case (wb.load_funct3_w)
      3'b000:  load_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001:  load_data = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b100:  load_data = {{(XLEN-8){1'b0}}, ld_byte};
      3'b101:  load_data = {{(XLEN-16){1'b0}}, ld_half};
      default: load_data = wb.dmem_readdata_w_in;
    endcase
  end
`else
  logic unused_load_fmt;

  assign unused_load_fmt = ^{wb.load_funct3_w, wb.load_byte_off_w};
  assign load_data       = wb.dmem_readdata_w_in;
`endif

  always_comb begin
    case (wb.reg_writedata_sel_w)
      2'b00:   sel_data = load_data;
      2'b10:   sel_data = wb.pc_plus4_w_in;
      default: sel_data = wb.execute_out_w_in;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    // WAW squash: the younger pipeline write supersedes any queued result to the same register.
    for (int unsigned i = 0; i < Q_DEPTH; i++) begin
      if (slot_busy && (addr_q[i] == wb.reg_write_addr_w_in)) valid_d[i] = 1'b0;
    end
    if (pop)  valid_d[head_q] = 1'b0;
    if (push) valid_d[tail_q] = push_valid;
  end

  always_comb begin
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      for (int unsigned i = 0; i < Q_DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      if (pop) head_q <= head_q + PtrW'(1);
      if (push) begin
        tail_q         <= tail_q + PtrW'(1);
        addr_q[tail_q] <= wb.lu_addr;
        data_q[tail_q] <= wb.lu_data;
      end
    end
  end

  logic [XLEN-1:0]    wdata;
  logic [RADDR_W-1:0] waddr;
  logic               wen;

  always_comb begin
    wdata = '0;
    waddr = '0;
    wen   = 1'b0;
    if (slot_busy) begin
      wdata = sel_data;
      waddr = wb.reg_write_addr_w_in;
      wen   = 1'b1;
    end else if (drain) begin
      wdata = data_q[head_q];
      waddr = addr_q[head_q];
      wen   = 1'b1;
    end
  end

  assign wb.reg_writedata_w      = wdata;
  assign wb.reg_write_addr_w_out = waddr;
  assign wb.reg_write_en_w_out   = wen;
  assign wb.lu_ready             = !q_full;
  assign wb.q_count              = count_q;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed self-checking bench for writeback_arbiter.
module tb_writeback_arbiter;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  writeback_arbiter_if #(.XLEN(32), .RADDR_W(5), .Q_DEPTH(4)) bus ();

  writeback_arbiter #(.XLEN(32), .RADDR_W(5), .Q_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [37:0] out_vec();
    return {bus.reg_write_en_w_out, bus.reg_write_addr_w_out, bus.reg_writedata_w};
  endfunction

  function automatic logic [37:0] wr(input logic [4:0] a, input logic [31:0] d);
    return {1'b1, a, d};
  endfunction

  function automatic logic [3:0] rq();
    return {bus.lu_ready, bus.q_count};
  endfunction

  task automatic drive_idle();
    bus.dmem_readdata_w_in  = '0;
    bus.execute_out_w_in    = '0;
    bus.pc_plus4_w_in       = '0;
    bus.reg_writedata_sel_w = 2'b01;
    bus.load_funct3_w       = '0;
    bus.load_byte_off_w     = '0;
    bus.reg_write_addr_w_in = '0;
    bus.reg_write_en_w_in   = 1'b0;
    bus.lu_valid            = 1'b0;
    bus.lu_data             = '0;
    bus.lu_addr             = '0;
  endtask

  task automatic pipe(input logic [4:0] a, input logic [31:0] d);
    bus.reg_write_en_w_in   = 1'b1;
    bus.reg_write_addr_w_in = a;
    bus.reg_writedata_sel_w = 2'b01;
    bus.execute_out_w_in    = d;
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    bus.lu_valid = 1'b1;
    bus.lu_addr  = a;
    bus.lu_data  = d;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    n_cmp++;
    if (out_vec() !== 38'h0) begin
      n_fail++; $display("FAIL reset_out got=%h want=%h", out_vec(), 38'h0);
    end
    n_cmp++;
    if (rq() !== 4'b1000) begin
      n_fail++; $display("FAIL reset_ready_count got=%b want=%b", rq(), 4'b1000);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_pipe_and_push();
    @(negedge clk); drive_idle(); pipe(5'd5, 32'h1234); push(5'd7, 32'hAA); #1;
    n_cmp++;
    if (out_vec() !== wr(5'd5, 32'h1234)) begin
      n_fail++; $display("FAIL pipe_x5 got=%h want=%h", out_vec(), wr(5'd5, 32'h1234));
    end
    @(negedge clk); drive_idle(); #1;
    n_cmp++;
    if (out_vec() !== wr(5'd7, 32'hAA) || rq() !== 4'b1001) begin
      n_fail++; $display("FAIL drain_x7 got=%h/%b want=%h/%b", out_vec(), rq(),
                         wr(5'd7, 32'hAA), 4'b1001);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (out_vec() !== 38'h0 || rq() !== 4'b1000) begin
      n_fail++; $display("FAIL after_x7_idle got=%h/%b want=%h/%b", out_vec(), rq(),
                         38'h0, 4'b1000);
    end
  endtask

  task automatic test_fill_drain();
    logic [37:0] exp_out [5];
    logic [3:0]  exp_rq  [5];
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); drive_idle(); pipe(5'd1, 32'h100); push(5'(10 + k), 32'hA0 + k); #1;
      n_cmp++;
      if (rq() !== {1'b1, 3'(k)}) begin
        n_fail++; $display("FAIL fill_%0d got=%b want=%b", k, rq(), {1'b1, 3'(k)});
      end
    end
    // Full: the x20 push must be refused here and in the next cycle.
    @(negedge clk); drive_idle(); pipe(5'd1, 32'h100); push(5'd20, 32'hEE); #1;
    n_cmp++;
    if (rq() !== 4'b0100 || out_vec() !== wr(5'd1, 32'h100)) begin
      n_fail++; $display("FAIL full got=%b/%h want=%b/%h", rq(), out_vec(), 4'b0100,
                         wr(5'd1, 32'h100));
    end
    @(negedge clk); drive_idle(); push(5'd20, 32'hEE); #1;
    n_cmp++;
    if (out_vec() !== wr(5'd10, 32'hA0) || rq() !== 4'b0100) begin
      n_fail++; $display("FAIL first_pop got=%h/%b want=%h/%b", out_vec(), rq(),
                         wr(5'd10, 32'hA0), 4'b0100);
    end
    @(negedge clk); drive_idle(); push(5'd14, 32'hA4); #1;
    n_cmp++;
    if (out_vec() !== wr(5'd11, 32'hA1) || rq() !== 4'b1011) begin
      n_fail++; $display("FAIL push_pop got=%h/%b want=%h/%b", out_vec(), rq(),
                         wr(5'd11, 32'hA1), 4'b1011);
    end
    exp_out[0] = wr(5'd12, 32'hA2); exp_rq[0] = 4'b1011;
    exp_out[1] = wr(5'd13, 32'hA3); exp_rq[1] = 4'b1010;
    exp_out[2] = wr(5'd14, 32'hA4); exp_rq[2] = 4'b1001;
    exp_out[3] = 38'h0;             exp_rq[3] = 4'b1000;
    exp_out[4] = 38'h0;             exp_rq[4] = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); drive_idle(); #1;
      n_cmp++;
      if (out_vec() !== exp_out[k] || rq() !== exp_rq[k]) begin
        n_fail++; $display("FAIL drain_%0d got=%h/%b want=%h/%b", k, out_vec(), rq(),
                           exp_out[k], exp_rq[k]);
      end
    end
  endtask

  task automatic test_squash();
    @(negedge clk); drive_idle(); pipe(5'd1, 32'h33); push(5'd9, 32'h11); #1;
    @(negedge clk); drive_idle(); pipe(5'd9, 32'h22); #1;
    n_cmp++;
    if (out_vec() !== wr(5'd9, 32'h22) || rq() !== 4'b1001) begin
      n_fail++; $display("FAIL squash_pipe got=%h/%b want=%h/%b", out_vec(), rq(),
                         wr(5'd9, 32'h22), 4'b1001);
    end
    @(negedge clk); drive_idle(); #1;
    n_cmp++;
    if (out_vec() !== 38'h0 || rq() !== 4'b1001) begin
      n_fail++; $display("FAIL squash_nowrite got=%h/%b want=%h/%b", out_vec(), rq(),
                         38'h0, 4'b1001);
    end
    @(negedge clk); drive_idle(); #1;
    n_cmp++;
    if (out_vec() !== 38'h0 || rq() !== 4'b1000) begin
      n_fail++; $display("FAIL squash_popped got=%h/%b want=%h/%b", out_vec(), rq(),
                         38'h0, 4'b1000);
    end
    // Same-cycle push to the register being written is stored dead; it pops under a busy slot.
    @(negedge clk); drive_idle(); pipe(5'd9, 32'h44); push(5'd9, 32'h55); #1;
    @(negedge clk); drive_idle(); pipe(5'd2, 32'h66); #1;
    n_cmp++;
    if (out_vec() !== wr(5'd2, 32'h66) || rq() !== 4'b1001) begin
      n_fail++; $display("FAIL squash_push got=%h/%b want=%h/%b", out_vec(), rq(),
                         wr(5'd2, 32'h66), 4'b1001);
    end
    @(negedge clk); drive_idle(); #1;
    n_cmp++;
    if (out_vec() !== 38'h0 || rq() !== 4'b1000) begin
      n_fail++; $display("FAIL squash_busy_pop got=%h/%b want=%h/%b", out_vec(), rq(),
                         38'h0, 4'b1000);
    end
  endtask

  task automatic test_x0();
    @(negedge clk); drive_idle(); pipe(5'd0, 32'hDEAD); push(5'd0, 32'h77); #1;
    n_cmp++;
    if (out_vec() !== 38'h0) begin
      n_fail++; $display("FAIL x0_pipe got=%h want=%h", out_vec(), 38'h0);
    end
    @(negedge clk); drive_idle(); #1;
    n_cmp++;
    if (out_vec() !== 38'h0 || rq() !== 4'b1001) begin
      n_fail++; $display("FAIL x0_queued got=%h/%b want=%h/%b", out_vec(), rq(),
                         38'h0, 4'b1001);
    end
    @(negedge clk); drive_idle(); #1;
    n_cmp++;
    if (out_vec() !== 38'h0 || rq() !== 4'b1000) begin
      n_fail++; $display("FAIL x0_popped got=%h/%b want=%h/%b", out_vec(), rq(),
                         38'h0, 4'b1000);
    end
  endtask

  task automatic test_reset_mid_drain();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); drive_idle(); pipe(5'd1, 32'h200); push(5'(20 + k), 32'hB0 + k); #1;
    end
    @(negedge clk); drive_idle(); #1;
    n_cmp++;
    if (out_vec() !== wr(5'd20, 32'hB0) || rq() !== 4'b1011) begin
      n_fail++; $display("FAIL mid_drain got=%h/%b want=%h/%b", out_vec(), rq(),
                         wr(5'd20, 32'hB0), 4'b1011);
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if (out_vec() !== 38'h0 || rq() !== 4'b1000) begin
      n_fail++; $display("FAIL async_reset got=%h/%b want=%h/%b", out_vec(), rq(),
                         38'h0, 4'b1000);
    end
    @(negedge clk); @(negedge clk); rst = 1'b0; #1;
    @(negedge clk); #1;
    n_cmp++;
    if (out_vec() !== 38'h0 || rq() !== 4'b1000) begin
      n_fail++; $display("FAIL post_reset got=%h/%b want=%h/%b", out_vec(), rq(),
                         38'h0, 4'b1000);
    end
  endtask

  task automatic test_sources();
    logic [2:0]  f3  [8];
    logic [1:0]  off [8];
    logic [31:0] exp [8];
    f3[0] = 3'b000; off[0] = 2'd1; exp[0] = 32'h0000007F;
    f3[1] = 3'b000; off[1] = 2'd3; exp[1] = 32'hFFFFFF80;
    f3[2] = 3'b101; off[2] = 2'd2; exp[2] = 32'h000080FF;
    f3[3] = 3'b001; off[3] = 2'd0; exp[3] = 32'h00007F01;
    f3[4] = 3'b100; off[4] = 2'd3; exp[4] = 32'h00000080;
    f3[5] = 3'b001; off[5] = 2'd2; exp[5] = 32'hFFFF80FF;
    f3[6] = 3'b101; off[6] = 2'd3; exp[6] = 32'h00000080;
    f3[7] = 3'b010; off[7] = 2'd0; exp[7] = 32'h80FF7F01;
`ifndef WB_LOAD_EXT_EN
    for (int k = 0; k < 8; k++) exp[k] = 32'h80FF7F01;
`endif
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); drive_idle(); pipe(5'd4, 32'h0BAD);
      bus.reg_writedata_sel_w = 2'b00;
      bus.dmem_readdata_w_in  = 32'h80FF7F01;
      bus.load_funct3_w       = f3[k];
      bus.load_byte_off_w     = off[k];
      #1;
      n_cmp++;
      if (out_vec() !== wr(5'd4, exp[k])) begin
        n_fail++; $display("FAIL load_%0d got=%h want=%h", k, out_vec(), wr(5'd4, exp[k]));
      end
    end
    @(negedge clk); drive_idle(); pipe(5'd31, 32'h0BAD);
    bus.reg_writedata_sel_w = 2'b10; bus.pc_plus4_w_in = 32'h0000_1004; #1;
    n_cmp++;
    if (out_vec() !== wr(5'd31, 32'h0000_1004)) begin
      n_fail++; $display("FAIL sel_pc4 got=%h want=%h", out_vec(), wr(5'd31, 32'h1004));
    end
    bus.reg_writedata_sel_w = 2'b11; #1;
    n_cmp++;
    if (out_vec() !== wr(5'd31, 32'h0BAD)) begin
      n_fail++; $display("FAIL sel_rsvd got=%h want=%h", out_vec(), wr(5'd31, 32'h0BAD));
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    drive_idle();
    test_reset();
    test_pipe_and_push();
    test_fill_drain();
    test_squash();
    test_x0();
    test_sources();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
